fetch_pc_unit: RTL and testbench

Parametrised next-generation program counter for the fetch stage: selects the next instruction address from reset, pipeline flush, jump, call, return and predicted-taken branch sources, with a configurable instruction step. Adds a circular return address stack (RAS) so calls and returns are redirected at decode without waiting for execute. Sits between the branch predictor / decode and instruction memory. Also keeps a free-running cycle counter.

---
 rtl/fetch_pc_unit.sv | 108 ++++++++++
 tb/tb_fetch_pc_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter with redirect sources, a circular return
// address stack for zero-bubble call/return, and a free-running cycle counter.
module fetch_pc_unit #(
  parameter int ADDR_WIDTH  = 16,
  parameter int PC_STEP     = 2,
  parameter int RAS_DEPTH   = 4,
  parameter int CYCLE_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [ADDR_WIDTH-1:0]  flush_address,
  input  logic                   ras_clear,
  input  logic                   is_jmp,
  input  logic                   is_call,
  input  logic                   is_ret,
  input  logic                   is_branch,
  input  logic                   take_branch,
  input  logic [ADDR_WIDTH-1:0]  target_address,
  input  logic [ADDR_WIDTH-1:0]  branch_predict,
  input  logic [ADDR_WIDTH-1:0]  decode_pc,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   branch_taken,
  output logic [ADDR_WIDTH-1:0]  branch_taken_address,
  output logic                   ras_empty,
  output logic                   ras_full,
  output logic                   ras_underflow,
  output logic [CYCLE_WIDTH-1:0] cycle_count
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_COUNT = (PTR_W + 1)'(RAS_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

  logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]      ras_ptr;
  logic [PTR_W-1:0]      ras_top;
  logic [PTR_W:0]        ras_count;
  logic                  push_en;

  assign ras_top   = ras_ptr - 1'b1;
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == DEPTH_COUNT);

  // A call only pushes when no higher-priority source claims the edge.
  assign push_en = !reset && !flush && !stall && !is_ret && is_call;

  // Pushing at the pointer when full naturally overwrites the oldest entry.
  always_ff @(posedge clk) begin
    if (push_en) begin
      ras_mem[ras_ptr] <= decode_pc + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc                   <= '0;
      branch_taken         <= 1'b0;
      branch_taken_address <= '0;
      ras_underflow        <= 1'b0;
      cycle_count          <= '0;
      ras_ptr              <= '0;
      ras_count            <= '0;
    end else begin
      cycle_count   <= cycle_count + 1'b1;
      ras_underflow <= 1'b0;
      if (flush) begin
        pc           <= flush_address;
        branch_taken <= 1'b0;
        if (ras_clear) begin
          ras_ptr   <= '0;
          ras_count <= '0;
        end
      end else if (stall) begin
        pc <= pc;
      end else if (is_ret) begin
        branch_taken <= 1'b0;
        if (!ras_empty) begin
          pc        <= ras_mem[ras_top];
          ras_ptr   <= ras_top;
          ras_count <= ras_count - 1'b1;
        end else begin
          pc            <= target_address;
          ras_underflow <= 1'b1;
        end
      end else if (is_call) begin
        pc           <= target_address;
        branch_taken <= 1'b0;
        ras_ptr      <= ras_ptr + 1'b1;
        if (!ras_full) begin
          ras_count <= ras_count + 1'b1;
        end
      end else if (is_jmp) begin
        pc           <= target_address;
        branch_taken <= 1'b0;
      end else if (is_branch && take_branch) begin
        pc                   <= branch_predict;
        branch_taken         <= 1'b1;
        branch_taken_address <= branch_predict;
      end else begin
        pc           <= pc + STEP;
        branch_taken <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit with default parameters.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, flush, ras_clear;
  logic        is_jmp, is_call, is_ret, is_branch, take_branch;
  logic [15:0] flush_address, target_address, branch_predict, decode_pc;
  logic [15:0] pc, branch_taken_address;
  logic        branch_taken, ras_empty, ras_full, ras_underflow;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;
  int exp_cycles = 0;

  fetch_pc_unit #(.ADDR_WIDTH(16), .PC_STEP(2), .RAS_DEPTH(4), .CYCLE_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .flush_address(flush_address), .ras_clear(ras_clear),
    .is_jmp(is_jmp), .is_call(is_call), .is_ret(is_ret),
    .is_branch(is_branch), .take_branch(take_branch),
    .target_address(target_address), .branch_predict(branch_predict),
    .decode_pc(decode_pc), .pc(pc), .branch_taken(branch_taken),
    .branch_taken_address(branch_taken_address), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_underflow(ras_underflow), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic idleInputs();
    reset = 1'b0; stall = 1'b0; flush = 1'b0; ras_clear = 1'b0;
    is_jmp = 1'b0; is_call = 1'b0; is_ret = 1'b0;
    is_branch = 1'b0; take_branch = 1'b0;
    flush_address = '0; target_address = '0; branch_predict = '0; decode_pc = '0;
  endtask

  // Advance edges and sample 1 time unit after each one; tracks expected cycle count.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (reset) exp_cycles = 0;
      else exp_cycles++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doCall(input logic [15:0] dpc, input logic [15:0] tgt);
    idleInputs();
    is_call = 1'b1; decode_pc = dpc; target_address = tgt;
    applyStimulus(1);
    checkOutput("call_pc", pc, tgt);
  endtask

  initial begin
    idleInputs();
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("reset_pc", pc, 16'h0000);
    checkOutput("reset_cycles", cycle_count, 0);
    checkOutput("reset_ras_empty", ras_empty, 1);
    checkOutput("reset_bt", branch_taken, 0);
    checkOutput("reset_underflow", ras_underflow, 0);

    idleInputs();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1);
      checkOutput("seq_pc", pc, 16'(2 * i));
    end
    checkOutput("seq_cycles", cycle_count, 4);
    checkOutput("seq_ras_empty", ras_empty, 1);

    // Call then immediate return
    doCall(16'h0010, 16'h0100);
    checkOutput("call_ras_empty", ras_empty, 0);
    idleInputs();
    is_ret = 1'b1; target_address = 16'h0AAA;
    applyStimulus(1);
    checkOutput("ret_pc", pc, 16'h0012);
    checkOutput("ret_ras_empty", ras_empty, 1);
    checkOutput("ret_underflow", ras_underflow, 0);

    // Overflow the stack by one, then drain it past empty
    for (int i = 1; i <= 5; i++) begin
      doCall(16'(16 * i), 16'(16'h1000 + 16 * i));
      if (i == 3) checkOutput("ras_not_full", ras_full, 0);
    end
    checkOutput("ras_full", ras_full, 1);
    for (int i = 5; i >= 2; i--) begin
      idleInputs();
      is_ret = 1'b1; target_address = 16'h0777;
      applyStimulus(1);
      checkOutput("pop_pc", pc, 16'(16 * i + 2));
      checkOutput("pop_underflow", ras_underflow, 0);
    end
    checkOutput("drained_empty", ras_empty, 1);
    applyStimulus(1);
    checkOutput("underflow_pc", pc, 16'h0777);
    checkOutput("underflow_pulse", ras_underflow, 1);
    idleInputs();
    applyStimulus(1);
    checkOutput("underflow_clear", ras_underflow, 0);
    checkOutput("after_underflow_pc", pc, 16'h0779);

    // Predicted branch held through a stall
    is_branch = 1'b1; take_branch = 1'b1; branch_predict = 16'h0200;
    applyStimulus(1);
    checkOutput("br_pc", pc, 16'h0200);
    checkOutput("br_taken", branch_taken, 1);
    checkOutput("br_addr", branch_taken_address, 16'h0200);
    idleInputs();
    stall = 1'b1; is_jmp = 1'b1; target_address = 16'h0999;
    applyStimulus(3);
    checkOutput("stall_pc", pc, 16'h0200);
    checkOutput("stall_bt", branch_taken, 1);
    checkOutput("stall_cycles", cycle_count, exp_cycles);

    // Flush with RAS clear while stalled
    doCall(16'h0060, 16'h0400);
    checkOutput("call_clears_bt", branch_taken, 0);
    doCall(16'h0070, 16'h0500);
    idleInputs();
    stall = 1'b1; flush = 1'b1; flush_address = 16'h0300; ras_clear = 1'b1; is_ret = 1'b1;
    applyStimulus(1);
    checkOutput("flush_pc", pc, 16'h0300);
    checkOutput("flush_bt", branch_taken, 0);
    checkOutput("flush_ras_empty", ras_empty, 1);
    idleInputs();
    is_ret = 1'b1; target_address = 16'h0ABC;
    applyStimulus(1);
    checkOutput("cleared_ret_pc", pc, 16'h0ABC);
    checkOutput("cleared_underflow", ras_underflow, 1);

    // Flush without clear keeps RAS contents
    doCall(16'h0090, 16'h0A00);
    idleInputs();
    flush = 1'b1; flush_address = 16'h0B00;
    applyStimulus(1);
    checkOutput("flush_keep_pc", pc, 16'h0B00);
    idleInputs();
    is_ret = 1'b1;
    applyStimulus(1);
    checkOutput("flush_keep_ret", pc, 16'h0092);

    // Address wrap
    idleInputs();
    flush = 1'b1; flush_address = 16'hFFFE;
    applyStimulus(1);
    idleInputs();
    applyStimulus(1);
    checkOutput("wrap_pc", pc, 16'h0000);

    // Call outranks jump; return outranks call
    is_jmp = 1'b1; is_call = 1'b1; decode_pc = 16'h0080; target_address = 16'h0600;
    applyStimulus(1);
    checkOutput("jmpcall_pc", pc, 16'h0600);
    checkOutput("jmpcall_ras", ras_empty, 0);
    idleInputs();
    is_ret = 1'b1; is_call = 1'b1; decode_pc = 16'h0700; target_address = 16'h0800;
    applyStimulus(1);
    checkOutput("retcall_pc", pc, 16'h0082);
    checkOutput("retcall_ras", ras_empty, 1);

    // Reset in the middle of a call chain
    doCall(16'h00A0, 16'h0C00);
    idleInputs();
    reset = 1'b1; is_call = 1'b1; decode_pc = 16'h00B0; target_address = 16'h0D00;
    applyStimulus(1);
    checkOutput("midreset_pc", pc, 16'h0000);
    checkOutput("midreset_ras", ras_empty, 1);
    checkOutput("midreset_cycles", cycle_count, 0);
    idleInputs();
    applyStimulus(1);
    checkOutput("postreset_pc", pc, 16'h0002);
    checkOutput("postreset_cycles", cycle_count, exp_cycles);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
